// File: rtl/rgb2gray_stream.sv
// RGB888 -> 8-bit luma stream stage with programmable weights, counter-derived
// end-of-frame tagging, upstream last checking, and a 3-stage stallable pipeline.
module rgb2gray_stream #(
    parameter int unsigned IMG_W = 1920,
    parameter int unsigned IMG_H = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] in_data,
    input  logic        in_keep,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  coe_r,
    input  logic [7:0]  coe_g,
    input  logic [7:0]  coe_b,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        last_err,
    output logic        frame_done
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned PW = 16;
    localparam int unsigned YW = 10;

    logic          w_ce;
    logic          w_beat;
    logic          w_col_end;
    logic          w_row_end;
    logic          w_exp_last;
    logic          w_resync;
    logic          w_tag;
    logic [7:0]    w_sat;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic          r_s1_valid;
    logic          r_s1_last;
    logic [PW-1:0] r_pr;
    logic [PW-1:0] r_pg;
    logic [PW-1:0] r_pb;

    logic          r_s2_valid;
    logic          r_s2_last;
    logic [YW-1:0] r_y;

    // Whole pipeline moves as one; an empty output slot never blocks.
    assign w_ce     = ~out_valid | out_ready;
    assign in_ready = w_ce;
    assign w_beat   = in_valid & w_ce & in_keep;

    assign w_col_end  = (r_col == CW'(IMG_W - 1));
    assign w_row_end  = (r_row == RW'(IMG_H - 1));
    assign w_exp_last = w_col_end & w_row_end;
    assign w_resync   = in_last & ~w_exp_last;
    assign w_tag      = w_exp_last | in_last;

    assign w_sat = (|r_y[YW-1:8]) ? 8'hFF : r_y[7:0];

    // Pixel position; an early upstream last restarts the frame at (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_beat) begin
            if (w_resync) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // S1 products, S2 rounded sum already scaled by 1/256, S3 saturated output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_pr       <= '0;
            r_pg       <= '0;
            r_pb       <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_y        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else if (w_ce) begin
            r_s1_valid <= w_beat;
            r_s1_last  <= w_beat & w_tag;
            r_pr       <= PW'(in_data[23:16]) * PW'(coe_r);
            r_pg       <= PW'(in_data[15:8])  * PW'(coe_g);
            r_pb       <= PW'(in_data[7:0])   * PW'(coe_b);
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_y        <= YW'((18'(r_pr) + 18'(r_pg) + 18'(r_pb) + 18'd128) >> 8);
            out_valid  <= r_s2_valid;
            out_last   <= r_s2_valid & r_s2_last;
            out_data   <= w_sat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            last_err   <= w_beat & (in_last != w_exp_last);
            frame_done <= out_valid & out_ready & out_last;
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream: scoreboard model indexed by frame position,
// per-cycle output checks, and literal latency/saturation expectations.
module tb_rgb2gray_stream;

    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
    localparam int unsigned N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_keep = 1'b0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  coe_r = 8'd77;
    logic [7:0]  coe_g = 8'd150;
    logic [7:0]  coe_b = 8'd29;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        last_err;
    logic        frame_done;

    rgb2gray_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .coe_r(coe_r), .coe_g(coe_g), .coe_b(coe_b),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .last_err(last_err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    function automatic int gray(input logic [23:0] px, input int cr, input int cg, input int cb);
        int y;
        y = (int'(px[23:16]) * cr + int'(px[15:8]) * cg + int'(px[7:0]) * cb + 128) / 256;
        return (y > 255) ? 255 : y;
    endfunction

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          pos = 0;
    bit          err_pend = 0;
    bit          fd_pend = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    int          n_out = 0, n_last = 0, n_fd = 0, n_err = 0;
    bit          bp_en = 0;
    bit          at_end;

    // Compare process: everything sampled mid-cycle, handshakes resolved for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pos = 0;
            err_pend = 0;
            fd_pend = 0;
            prev_stall = 0;
        end else begin
            check("last_err", last_err, err_pend);
            check("frame_done", frame_done, fd_pend);
            check("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (last_err) n_err++;
            if (frame_done) n_fd++;
            err_pend = 0;
            fd_pend = 0;
            if (out_valid && out_ready) begin
                n_out++;
                if (out_last) n_last++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0d required=none @%0t", out_data, $time);
                end else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
                fd_pend = out_last;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (in_valid && in_ready && in_keep) begin
                at_end = (pos == N - 1);
                e.data = gray(in_data, coe_r, coe_g, coe_b);
                e.last = at_end || in_last;
                q.push_back(e);
                err_pend = (in_last != at_end);
                if (in_last && !at_end) pos = 0;
                else pos = at_end ? 0 : pos + 1;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [23:0] d, input logic k, input logic l);
        bit ok;
        ok = 0;
        in_data = d;
        in_keep = k;
        in_last = l;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic drain;
        bit done;
        done = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (q.size() == 0) begin
                done = 1;
                break;
            end
        end
        repeat (3) tick();
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", q.size());
        end
    endtask

    task automatic latency_pixel(input logic [23:0] d, input int req);
        int n;
        in_data = d;
        in_keep = 1'b1;
        in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        check("latency", n, 3);
        check("pixel_value", out_data, req);
        tick();
        drain();
    endtask

    int b_out, b_last, b_fd, b_err;

    task automatic snap;
        b_out = n_out;
        b_last = n_last;
        b_fd = n_fd;
        b_err = n_err;
    endtask

    task automatic expect_counts(input string tag, input int o, input int l, input int f, input int r);
        check({tag, "_outputs"}, n_out - b_out, o);
        check({tag, "_out_last"}, n_last - b_last, l);
        check({tag, "_frame_done"}, n_fd - b_fd, f);
        check({tag, "_last_err"}, n_err - b_err, r);
    endtask

    function automatic logic [23:0] pat(input int i);
        return {8'(i * 37 + 11), 8'(i * 91 + 3), 8'(255 - i * 13)};
    endfunction

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_last_err", last_err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Literal pins: white at 77/150/29, mixed pixel, then saturating weights.
        latency_pixel({8'd255, 8'd255, 8'd255}, 255);
        latency_pixel({8'd100, 8'd50, 8'd200}, 82);
        coe_r = 8'd255; coe_g = 8'd255; coe_b = 8'd255;
        tick();
        latency_pixel({8'd255, 8'd255, 8'd255}, 255);
        coe_r = 8'd77; coe_g = 8'd150; coe_b = 8'd29;

        do_reset(2);
        snap();
        for (int i = 0; i < int'(N); i++) send(pat(i), 1'b1, 1'(i == int'(N) - 1));
        drain();
        expect_counts("frame", N, 1, 1, 0);

        snap();
        bp_en = 1;
        for (int i = 0; i < 3 * int'(N); i++)
            send(24'($urandom), 1'b1, 1'((i % int'(N)) == int'(N) - 1));
        drain();
        bp_en = 0;
        tick();
        expect_counts("backpressure", 3 * N, 3, 3, 0);

        do_reset(2);
        snap();
        for (int i = 0; i < 5; i++) send(pat(i + 40), 1'b1, 1'(i == 4));
        for (int i = 0; i < int'(N); i++) send(pat(i + 60), 1'b1, 1'(i == int'(N) - 1));
        drain();
        expect_counts("early_last", 5 + N, 2, 2, 1);

        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            send(pat(i + 80), 1'b1, 1'b0);
            send(pat(i + 90), 1'b0, 1'b1);
        end
        do_reset(2);
        check("post_reset_valid", out_valid, 0);
        snap();
        for (int i = 0; i < int'(N); i++) begin
            send(pat(i + 100), 1'b1, 1'(i == int'(N) - 1));
            if (i % 3 == 0) send(pat(i + 120), 1'b0, 1'b1);
        end
        drain();
        expect_counts("keep_reset", N, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb2gray_stream.md
# rgb2gray_stream

Upstream front-end of the edge-detection pipeline: accepts a 24-bit RGB pixel stream with valid/ready handshake, converts each pixel to 8-bit luma using runtime-programmable weights, and presents the result as the 8-bit gray stream consumed by the Gaussian stage. It regenerates an end-of-frame marker from pixel/line counters, flags mismatched upstream `last`, and propagates downstream backpressure through a 3-stage pipeline.

## Interface
- `IMG_W`, default 1920: pixels per line (≤ 2048, matches 11-bit line-buffer addressing).
- `IMG_H`, default 1080: lines per frame.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous active-high reset.
- `in_data` in 24: pixel, `{R[23:16], G[15:8], B[7:0]}`.
- `in_keep` in 1: 0 = null beat, consumed and discarded.
- `in_last` in 1: upstream end-of-frame marker.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid & in_ready`.
- `coe_r`, `coe_g`, `coe_b` in 8 each: luma weights, unsigned, quasi-static (changed only while idle).
- `out_data` out 8: gray pixel.
- `out_valid` out 1: output beat valid.
- `out_last` out 1: final pixel of frame (counter-derived).
- `out_ready` in 1: downstream ready (Gaussian stage `gauss_axi_ready`).
- `last_err` out 1: one-cycle pulse on `in_last` mismatch.
- `frame_done` out 1: one-cycle pulse when the `out_last` beat is transferred.

## Operation
- Pipeline enable: `ce = ~out_valid | out_ready`. `in_ready = ce`, combinational. All stages advance together on `ce`; stall freezes every stage.
- Accepted beat with `in_keep=1` enters stage 1 with valid=1. Otherwise stage 1 loads a bubble.
- S1: register `R*coe_r`, `G*coe_g`, `B*coe_b` as 16-bit each, plus the `last` tag.
- S2: `sum = p_r + p_g + p_b + 128`, 18-bit, no overflow possible.
- S3: `y = sum >> 8`. If `y > 255`, `out_data = 255`; else `out_data = y[7:0]`. Registered with `out_valid` and `out_last`.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted keep=1 beats.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 at IMG_H-1.
- `exp_last = (col==IMG_W-1) & (row==IMG_H-1)` at acceptance; it is the `last` tag carried down the pipeline.
- `in_last` checking, on an accepted keep=1 beat:
  - If `in_last != exp_last`, pulse `last_err` next cycle.
  - If `in_last=1` early, the beat is still tagged last, and `col`/`row` reset to 0 (frame resync).
  - If `in_last=0` at the expected end, the tag remains 1 and counters wrap normally.
- `in_last` on keep=0 beats is ignored.
- `frame_done` pulses the cycle after `out_valid & out_ready & out_last`.

## Timing
- Latency: 3 `clk` from accepted input to `out_valid`, absent stalls. Throughput is 1 pixel/cycle.
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `last_err`=0, `frame_done`=0, all stage valids 0, `col`=`row`=0. `in_ready`=1 during and after reset, since `out_valid`=0.
- `rst` asserted mid-frame: pipeline contents discarded, counters cleared. The next accepted beat is pixel (0,0).
- Stall: while `out_valid & ~out_ready`, `out_data`, `out_valid` and `out_last` are held stable and `in_ready`=0.
- A bubble in S3 with `out_ready`=0 still allows advance, because `ce`=1 when `out_valid`=0.
- Accept, counter wrap, and resync in the same cycle: resync takes priority; counters become 0/0.
- `coe_*` changes while data is in flight produce undefined pixels for up to 3 beats. No other effect.

## Test plan
- Single pixel `{255,255,255}`, weights 77/150/29, `out_ready`=1 -> `out_data`=255 exactly 3 cycles after acceptance. Pixel `{100,50,200}` -> (7700+7500+5800+128)>>8 = 82.
- Saturation: weights 255/255/255, pixel `{255,255,255}` -> sum 195203, >>8 = 762 -> `out_data`=255.
- Full frame with IMG_W=4, IMG_H=3, continuous valid, `in_last` on the 12th beat:
  - 12 outputs; `out_last` only on the 12th.
  - `frame_done` pulses once.
  - `last_err` never pulses.
- Backpressure: random `out_ready` (~50%) over 3 frames -> output sequence identical to the no-stall run, no drops or duplicates, outputs stable while stalled, `in_ready` low whenever `out_valid & ~out_ready`.
- Early `in_last` on beat 5 of a 4x3 frame:
  - `last_err` pulses; beat 5 exits with `out_last`=1.
  - Beat 6 is treated as (0,0); a frame-end-tagged 12th beat after it carries `out_last`.
- keep=0 beats interleaved, plus `rst` asserted mid-frame for 2 cycles:
  - Null beats produce no output and no counter advance.
  - After reset, the next frame emits exactly IMG_W*IMG_H beats with a correct `out_last`.
